// File: rtl/yarp_pkg.sv
// yarp_pkg: shared access-size and FSM state types plus the byte-enable helper
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        byte_en = size == WORD ? 4'hf : size == HALF_WORD ? 4'h3 << off : 4'h1 << off;
    endfunction

endpackage

// File: rtl/yarp_dmem_array.sv
// yarp_dmem_array: word storage with per-byte write enables and a registered read port
module yarp_dmem_array
    import yarp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_idx,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // byte-lane writes and a read registered every cycle; contents are never reset
    always_ff @(posedge clk) begin
        if (i_we)
            for (int b = 0; b < 4; b++)
                if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        o_rdata <= r_mem[i_idx];
    end

endmodule

// File: rtl/yarp_dmem.sv
// yarp_dmem: request/grant data memory with programmable wait cycles
// YARP_DMEM_MISALIGN_ERR_EN: misaligned halfword/word accesses error instead of being aligned
module yarp_dmem
    import yarp_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [1:0]  data_byte_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_rvalid;
    logic        r_err;

    // in IDLE the incoming request drives the datapath so a zero-wait access can commit on its grant edge
    logic        w_idle;
    logic        w_cur_wr;
    logic [1:0]  w_cur_size;
    logic [31:0] w_cur_addr;
    logic [31:0] w_cur_wdata;
    logic [31:0] w_addr;
    logic        w_mis;
    logic        w_err;
    logic        w_go_resp;
    logic        w_we;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_sh;
    logic [31:0] w_arr_rdata;
    logic [31:0] w_rd_sh;

    assign w_idle      = r_state == IDLE;
    assign w_cur_wr    = w_idle ? data_wr_i    : r_wr;
    assign w_cur_size  = w_idle ? data_byte_i  : r_size;
    assign w_cur_addr  = w_idle ? data_addr_i  : r_addr;
    assign w_cur_wdata = w_idle ? data_wdata_i : r_wdata;

`ifdef YARP_DMEM_MISALIGN_ERR_EN
    assign w_mis  = (w_cur_size == HALF_WORD && w_cur_addr[0]) ||
                    (w_cur_size == WORD && w_cur_addr[1:0] != 2'b00);
    assign w_addr = w_cur_addr;
`else
    assign w_mis  = 1'b0;
    assign w_addr = {w_cur_addr[31:2],
                     w_cur_size == WORD ? 2'b00 :
                     {w_cur_addr[1], w_cur_size == HALF_WORD ? 1'b0 : w_cur_addr[0]}};
`endif

    assign w_err      = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS)) || (w_cur_size == 2'b10) || w_mis;
    assign w_go_resp  = w_idle ? (data_req_i && WAIT_CYCLES == 0) : (r_state == WAIT && r_cnt == 4'd0);
    assign w_we       = w_go_resp && w_cur_wr && !w_err;
    assign w_be       = byte_en(w_cur_size, w_addr[1:0]);
    assign w_wdata_sh = w_cur_wdata << {w_addr[1:0], 3'b000};
    assign w_rd_sh    = w_arr_rdata >> {w_addr[1:0], 3'b000};

    assign data_gnt_o    = w_idle && data_req_i;
    assign data_rvalid_o = r_rvalid;
    assign data_err_o    = r_err;
    assign data_rdata_o  = !(r_rvalid && !r_err && !r_wr) ? 32'b0 :
                           r_size == BYTE      ? {24'b0, w_rd_sh[7:0]}  :
                           r_size == HALF_WORD ? {16'b0, w_rd_sh[15:0]} : w_rd_sh;

    yarp_dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .i_we   (w_we),
        .i_be   (w_be),
        .i_idx  (w_addr[AW+1:2]),
        .i_wdata(w_wdata_sh),
        .o_rdata(w_arr_rdata)
    );

    // request sequencing: latch on grant, count wait cycles, one-cycle response strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_wr     <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= 32'b0;
            r_wdata  <= 32'b0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_go_resp;
            r_err    <= w_go_resp && w_err;
            case (r_state)
                IDLE: if (data_req_i) begin
                    r_wr    <= data_wr_i;
                    r_size  <= data_byte_i;
                    r_addr  <= data_addr_i;
                    r_wdata <= data_wdata_i;
                    if (WAIT_CYCLES == 0) r_state <= RESP;
                    else begin
                        r_state <= WAIT;
                        r_cnt   <= 4'(WAIT_CYCLES - 1);
                    end
                end
                WAIT: if (r_cnt == 4'd0) r_state <= RESP;
                      else r_cnt <= r_cnt - 4'd1;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_yarp_dmem.sv
// tb_yarp_dmem: directed checks of yarp_dmem at WAIT_CYCLES 0, 1 and 3
module tb_yarp_dmem;

    logic        clk = 1'b0;
    logic        rst  [3];
    logic        req  [3];
    logic        wr   [3];
    logic [1:0]  sz   [3];
    logic [31:0] addr [3];
    logic [31:0] wd   [3];
    logic        gnt  [3];
    logic        rv   [3];
    logic        er   [3];
    logic [31:0] rd   [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    yarp_dmem #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(rst[0]), .data_req_i(req[0]), .data_wr_i(wr[0]), .data_byte_i(sz[0]),
        .data_addr_i(addr[0]), .data_wdata_i(wd[0]), .data_gnt_o(gnt[0]), .data_rvalid_o(rv[0]),
        .data_rdata_o(rd[0]), .data_err_o(er[0]));

    yarp_dmem #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(rst[1]), .data_req_i(req[1]), .data_wr_i(wr[1]), .data_byte_i(sz[1]),
        .data_addr_i(addr[1]), .data_wdata_i(wd[1]), .data_gnt_o(gnt[1]), .data_rvalid_o(rv[1]),
        .data_rdata_o(rd[1]), .data_err_o(er[1]));

    yarp_dmem #(.WAIT_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(rst[2]), .data_req_i(req[2]), .data_wr_i(wr[2]), .data_byte_i(sz[2]),
        .data_addr_i(addr[2]), .data_wdata_i(wd[2]), .data_gnt_o(gnt[2]), .data_rvalid_o(rv[2]),
        .data_rdata_o(rd[2]), .data_err_o(er[2]));

    // one access on instance d, starting mid-cycle with the DUT idle; lat counts edges from grant to rvalid
    task automatic access(input int d, input logic w, input logic [1:0] s, input logic [31:0] a,
                          input logic [31:0] dat, output logic g, output logic [31:0] q,
                          output logic e, output int lat, output logic quiet);
        req[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wd[d] = dat;
        #1;
        g = gnt[d]; lat = 0; q = 'x; e = 'x;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            req[d] = 1'b0;
            if (rv[d]) begin
                lat = n; q = rd[d]; e = er[d];
                break;
            end
        end
        @(posedge clk); #1;
        quiet = rv[d] === 1'b0 && rd[d] === 32'b0 && er[d] === 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            total++;
            if ({gnt[d], rv[d], er[d], rd[d]} !== 35'b0) begin
                bad++;
                $display("FAIL reset_outputs dut%0d got gnt=%b rv=%b err=%b rdata=%h want all 0", d, gnt[d], rv[d], er[d], rd[d]);
            end
        end
    endtask

    task automatic test_word();
        logic g, e, qt; logic [31:0] q; int lat;
        access(1, 1'b1, 2'b11, 32'h10, 32'hdeadbeef, g, q, e, lat, qt);
        total++; if (g !== 1'b1) begin bad++; $display("FAIL sw_gnt got %b want 1", g); end
        total++; if (lat != 2) begin bad++; $display("FAIL sw_latency got %0d want 2", lat); end
        total++; if ({e, q} !== 33'b0) begin bad++; $display("FAIL sw_resp got err=%b rdata=%h want 0/0", e, q); end
        total++; if (qt !== 1'b1) begin bad++; $display("FAIL sw_after_resp outputs not zero"); end
        access(1, 1'b0, 2'b11, 32'h10, 32'h0, g, q, e, lat, qt);
        total++; if (g !== 1'b1 || lat != 2) begin bad++; $display("FAIL lw_timing got gnt=%b lat=%0d want 1/2", g, lat); end
        total++; if (q !== 32'hdeadbeef || e !== 1'b0) begin bad++; $display("FAIL lw_10 got %h err=%b want deadbeef/0", q, e); end
    endtask

    task automatic test_subword();
        logic g, e, qt; logic [31:0] q; int lat;
        access(1, 1'b1, 2'b00, 32'h12, 32'hffffff55, g, q, e, lat, qt);
        total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_err got %b want 0", e); end
        access(1, 1'b0, 2'b00, 32'h12, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'h00000055) begin bad++; $display("FAIL lbu_12 got %h want 00000055", q); end
        access(1, 1'b0, 2'b11, 32'h10, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'hde55beef) begin bad++; $display("FAIL lw_after_sb got %h want de55beef", q); end
        access(1, 1'b0, 2'b01, 32'h12, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'h0000de55) begin bad++; $display("FAIL lh_12 got %h want 0000de55", q); end
        access(1, 1'b0, 2'b00, 32'h13, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'h000000de) begin bad++; $display("FAIL lbu_13 got %h want 000000de", q); end
        access(1, 1'b1, 2'b01, 32'h16, 32'h1234a5c3, g, q, e, lat, qt);
        access(1, 1'b0, 2'b01, 32'h16, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'h0000a5c3) begin bad++; $display("FAIL lh_16 got %h want 0000a5c3", q); end
        access(1, 1'b0, 2'b00, 32'h17, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'h000000a5) begin bad++; $display("FAIL lbu_17 got %h want 000000a5", q); end
    endtask

    task automatic test_misalign();
        logic g, e, qt; logic [31:0] q; int lat;
        access(1, 1'b0, 2'b11, 32'h11, 32'h0, g, q, e, lat, qt);
`ifdef YARP_DMEM_MISALIGN_ERR_EN
        total++; if (e !== 1'b1 || q !== 32'b0) begin bad++; $display("FAIL lw_11 got err=%b rdata=%h want 1/0", e, q); end
        access(1, 1'b0, 2'b01, 32'h13, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b1 || q !== 32'b0) begin bad++; $display("FAIL lh_13 got err=%b rdata=%h want 1/0", e, q); end
        access(1, 1'b1, 2'b11, 32'h11, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL sw_11 got err=%b want 1", e); end
        access(1, 1'b0, 2'b11, 32'h10, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'hde55beef) begin bad++; $display("FAIL word_10_kept got %h want de55beef", q); end
`else
        total++; if (e !== 1'b0 || q !== 32'hde55beef) begin bad++; $display("FAIL lw_11 got err=%b rdata=%h want 0/de55beef", e, q); end
        access(1, 1'b0, 2'b01, 32'h13, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b0 || q !== 32'h0000de55) begin bad++; $display("FAIL lh_13 got err=%b rdata=%h want 0/0000de55", e, q); end
`endif
    endtask

    task automatic test_range();
        logic g, e, qt; logic [31:0] q; int lat;
        access(1, 1'b1, 2'b11, 32'h0, 32'h11111111, g, q, e, lat, qt);
        access(1, 1'b1, 2'b11, 32'h1000, 32'hffffffff, g, q, e, lat, qt);
        total++; if (e !== 1'b1 || q !== 32'b0) begin bad++; $display("FAIL sw_1000 got err=%b rdata=%h want 1/0", e, q); end
        access(1, 1'b0, 2'b11, 32'h0, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'h11111111) begin bad++; $display("FAIL word_0_kept got %h want 11111111", q); end
        access(1, 1'b0, 2'b11, 32'h1000, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b1 || q !== 32'b0) begin bad++; $display("FAIL lw_1000 got err=%b rdata=%h want 1/0", e, q); end
        access(1, 1'b1, 2'b10, 32'h10, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b1) begin bad++; $display("FAIL sz10_store got err=%b want 1", e); end
        access(1, 1'b0, 2'b10, 32'h10, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b1 || q !== 32'b0) begin bad++; $display("FAIL sz10_load got err=%b rdata=%h want 1/0", e, q); end
        access(1, 1'b0, 2'b11, 32'h10, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'hde55beef) begin bad++; $display("FAIL word_10_after_sz10 got %h want de55beef", q); end
        access(1, 1'b1, 2'b11, 32'hffc, 32'ha0b0c0d0, g, q, e, lat, qt);
        access(1, 1'b0, 2'b11, 32'hffc, 32'h0, g, q, e, lat, qt);
        total++; if (e !== 1'b0 || q !== 32'ha0b0c0d0) begin bad++; $display("FAIL lw_ffc got err=%b rdata=%h want 0/a0b0c0d0", e, q); end
    endtask

    task automatic test_back_to_back();
        logic g, e, qt; logic [31:0] q; int lat; logic [5:0] gp, rp; logic late;
        access(0, 1'b1, 2'b11, 32'h4, 32'h00000077, g, q, e, lat, qt);
        access(0, 1'b0, 2'b11, 32'h4, 32'h0, g, q, e, lat, qt);
        total++; if (lat != 1 || q !== 32'h77) begin bad++; $display("FAIL w0_lw got lat=%0d rdata=%h want 1/00000077", lat, q); end
        gp = '0; rp = '0; late = 1'b0;
        req[0] = 1'b1; wr[0] = 1'b0; sz[0] = 2'b11; addr[0] = 32'h4;
        #1;
        for (int i = 0; i < 6; i++) begin
            gp[i] = gnt[0];
            @(posedge clk); #1;
            rp[i] = rv[0];
        end
        req[0] = 1'b0;
        repeat (2) begin @(posedge clk); #1; late |= rv[0]; end
        total++; if (gp !== 6'b010101) begin bad++; $display("FAIL b2b_gnt got %b want 010101", gp); end
        total++; if (rp !== 6'b010101) begin bad++; $display("FAIL b2b_rvalid got %b want 010101", rp); end
        total++; if (late !== 1'b0) begin bad++; $display("FAIL b2b_extra_rvalid got %b want 0", late); end
    endtask

    task automatic test_reset_abort();
        logic g, e, qt; logic [31:0] q; int lat; logic seen;
        access(2, 1'b1, 2'b11, 32'h20, 32'hcafef00d, g, q, e, lat, qt);
        total++; if (lat != 4 || e !== 1'b0) begin bad++; $display("FAIL w3_sw got lat=%0d err=%b want 4/0", lat, e); end
        req[2] = 1'b1; wr[2] = 1'b1; sz[2] = 2'b11; addr[2] = 32'h20; wd[2] = 32'h12345678;
        #1;
        total++; if (gnt[2] !== 1'b1) begin bad++; $display("FAIL abort_gnt got %b want 1", gnt[2]); end
        @(posedge clk); #1;
        req[2] = 1'b0; rst[2] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 1) rst[2] = 1'b0;
            seen |= rv[2];
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL abort_rvalid got %b want 0", seen); end
        access(2, 1'b0, 2'b11, 32'h20, 32'h0, g, q, e, lat, qt);
        total++; if (q !== 32'hcafef00d || lat != 4) begin bad++; $display("FAIL abort_kept got %h lat=%0d want cafef00d/4", q, lat); end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req[d] = 1'b0; wr[d] = 1'b0; sz[d] = 2'b00; addr[d] = '0; wd[d] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        #1;
        test_reset();
        @(posedge clk); #1;
        test_word();
        test_subword();
        test_misalign();
        test_range();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/yarp_dmem.md
YARP_DMEM -- requirements
Module: yarp_dmem

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, sets the number of 32-bit words in storage.
REQ-002 Parameter WAIT_CYCLES, default 1, sets the extra wait cycles between grant and response; legal range 0..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_req_i  input  1  request valid.
REQ-006 data_wr_i  input  1  1 = store, 0 = load.
REQ-007 data_byte_i  input  2  access size: BYTE, HALF_WORD or WORD.
REQ-008 data_addr_i  input  32  byte address.
REQ-009 data_wdata_i  input  32  store data, right-justified.
REQ-010 data_gnt_o  output  1  request accepted this cycle.
REQ-011 data_rvalid_o  output  1  one-cycle response strobe.
REQ-012 data_rdata_o  output  32  load data, right-justified and zero-filled above the access size.
REQ-013 data_err_o  output  1  response carries an error; valid only with data_rvalid_o.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 IDLE: data_gnt_o = data_req_i (combinational). On a grant, latch wr, size, addr and wdata.
REQ-016 IDLE exit: on a grant, go to WAIT when WAIT_CYCLES > 0 (load counter with WAIT_CYCLES-1), else go to RESP.
REQ-017 WAIT: decrement the counter each cycle; go to RESP at counter 0.
REQ-018 data_gnt_o SHALL be 0 in WAIT and RESP; a request held during those states is granted on return to IDLE.
REQ-019 RESP lasts exactly one cycle with data_rvalid_o = 1, then returns to IDLE.
REQ-020 Grant-to-rvalid latency SHALL be WAIT_CYCLES+1 cycles.
REQ-021 Peak throughput SHALL be one access per WAIT_CYCLES+2 cycles.
REQ-022 Stores SHALL commit on the edge entering RESP, using byte enables derived from size and addr[1:0] and wdata shifted to the addressed lane.
REQ-023 Loads SHALL register data on the edge entering RESP: word >> (8*addr[1:0]), masked to 8/16/32 bits.
REQ-024 data_rdata_o SHALL be 0 for stores and for errored responses.
REQ-025 A word index addr[31:2] >= DEPTH_WORDS SHALL give data_err_o = 1 with no write.
REQ-026 Size encoding 2'b10 SHALL give data_err_o = 1 with no write.
REQ-027 Outputs SHALL be 0 whenever data_rvalid_o = 0.

Reset
REQ-028 Reset SHALL force state IDLE, counter 0, all registered outputs 0 and the latched request 0.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Reset asserted in WAIT or RESP SHALL abort the access: no write commits and no rvalid is produced.

Configuration
REQ-031 Macro YARP_DMEM_MISALIGN_ERR_EN controls misalignment handling.
REQ-032 With YARP_DMEM_MISALIGN_ERR_EN defined, a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, SHALL respond with data_err_o = 1 and no write.
REQ-033 Without YARP_DMEM_MISALIGN_ERR_EN, low address bits SHALL be forced to alignment (halfword clears bit 0, word clears bits 1:0) and no misalignment error is raised.

Structure
REQ-034 Size typedef (BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b11) and the FSM state enum SHALL live in yarp_pkg.
REQ-035 Storage SHALL be a sub-module yarp_dmem_array: synchronous write with 4 byte enables and registered read.

Verification
REQ-036 WAIT_CYCLES=1: SW 0xDEADBEEF to 0x10, then LW 0x10 -> gnt in the request cycle, rvalid 2 cycles later, rdata=0xDEADBEEF, err=0.
REQ-037 After REQ-036: SB 0x55 to 0x12, then LBU 0x12 -> 0x00000055; LW 0x10 -> 0xDE55BEEF; LH 0x12 -> 0x0000DE55.
REQ-038 Macro defined: LW 0x11 -> err=1, rdata=0; word 0x10 unchanged. Macro undefined: LW 0x11 -> 0xDE55BEEF, err=0.
REQ-039 DEPTH_WORDS=1024: SW to 0x1000 -> err=1, no write; size 2'b10 -> err=1.
REQ-040 data_req_i held high for 6 cycles with WAIT_CYCLES=0 -> gnt pulses every 2nd cycle, 3 rvalid pulses.
REQ-041 Reset asserted one cycle after granting SW 0x12345678 to 0x20 (WAIT_CYCLES=3) -> no rvalid; a later LW 0x20 returns the prior contents.
